// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI mode-0 master among NUM_REQ clients.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module spi_xfer_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      sclk,
  output logic                      cs_n,
  output logic                      mosi,
  input  logic                      miso
);

  localparam int PW   = $clog2(NUM_REQ);
  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(2 * DATA_W + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_PRE   = CW'(CLK_DIV - 2);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [HW-1:0]       half_q, half_d;
  logic                sclk_q, sclk_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;
  logic [PW-1:0]       own_q, own_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [PW-1:0]       win;
  logic                any;
`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [PW-1:0]       rr_q, rr_d;
`endif

  always_comb begin
    win = '0;
    any = 1'b0;
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win = PW'(i);
        any = 1'b1;
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[idx]) begin
        win = PW'(idx);
        any = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    half_d  = half_q;
    sclk_d  = sclk_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rsp_d   = rsp_q;
    own_d   = own_q;
    done_d  = '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any) begin
          state_d = SETUP;
          tx_d    = req_data[win*DATA_W +: DATA_W];
          own_d   = win;
`ifndef SPI_ARB_FIXED_PRIO_EN
          rr_d    = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          half_d = half_q + 1'b1;
          sclk_d = ~sclk_q;
          // low->high samples miso; high->low advances mosi except last
          if (!sclk_q) begin
            rx_d = {rx_q[DATA_W-2:0], miso};
          end else if (half_q != HALF_LAST) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (half_q == HALF_LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == DIV_PRE) begin
          done_d = NUM_REQ'(1) << own_q;
          rsp_d  = rx_q;
        end
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rsp_q   <= '0;
      own_q   <= '0;
      done_q  <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rsp_q   <= rsp_d;
      own_q   <= own_d;
      done_q  <= done_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign gnt      = (state_q == IDLE && any) ? (NUM_REQ'(1) << win) : '0;
  assign busy     = (state_q != IDLE) | any;
  assign done     = done_q;
  assign rsp_data = rsp_q;
  assign sclk     = sclk_q;
  assign cs_n     = (state_q == IDLE) || (state_q == GAP);
  assign mosi     = !cs_n & tx_q[DATA_W-1];

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Randomized bench for spi_xfer_arbiter against a cycle-offset model.
// Honors SPI_ARB_FIXED_PRIO_EN in the reference arbitration.
module tb_spi_xfer_arbiter;

  localparam int NR      = 3;
  localparam int DW      = 32;
  localparam int CD      = 4;
  localparam int CG      = 2;
  localparam int DONE_AT = (2 * DW + 2) * CD;
  localparam int SH_LO   = CD + 1;
  localparam int SH_HI   = CD + 2 * DW * CD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             miso = 1'b0;
  logic [NR-1:0]    gnt, done;
  logic [DW-1:0]    rsp_data;
  logic             busy, sclk, cs_n, mosi;

  spi_xfer_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(CD), .CS_GAP(CG)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .rsp_data(rsp_data), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  logic [1:0] req2 = '0;
  logic [7:0] data2 = '0;
  logic [1:0] gnt2, done2;
  logic [7:0] rsp2;
  logic       busy2, sclk2, cs2, mosi2;

  spi_xfer_arbiter #(
    .NUM_REQ(2), .DATA_W(8), .CLK_DIV(2), .CS_GAP(1)
  ) u_lb (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_data({8'h00, data2}),
    .gnt(gnt2), .done(done2), .rsp_data(rsp2), .busy(busy2),
    .sclk(sclk2), .cs_n(cs2), .mosi(mosi2), .miso(mosi2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit            act = 0;
  int            t0 = 0;
  int            own = 0;
  int            rr = 0;
  int            cyc = 0;
  int            rises = 0;
  bit            psclk = 0;
  bit            first = 1;
  bit [NR-1:0]   pend = '0;
  bit [NR-1:0]   gseen = '0;
  logic [DW-1:0] tx = '0;
  logic [DW-1:0] rxw = '0;
  logic [DW-1:0] last_rsp = '0;

  function automatic int pick(input logic [NR-1:0] r);
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NR; k++) if (r[(rr + k) % NR]) return (rr + k) % NR;
`endif
    return 0;
  endfunction

  task automatic model_check();
    logic [NR-1:0] eg, ed;
    logic eb, ecs, esc, emo;
    int o, k;
    eg = '0; ed = '0;
    eb = 1'b0; ecs = 1'b1; esc = 1'b0; emo = 1'b0;
    if (act && cyc - t0 > DONE_AT + CG) act = 0;
    if (!act && |req) begin
      own = pick(req);
      act = 1;
      t0 = cyc;
      tx = req_data[own*DW +: DW];
      rxw = first ? 32'h1234_5678 : $urandom;
      first = 0;
      rr = (own + 1) % NR;
      eg[own] = 1'b1;
      gseen[own] = 1'b1;
      rises = 0;
    end
    if (act) begin
      o = cyc - t0;
      eb = 1'b1;
      ecs = !(o >= 1 && o <= DONE_AT);
      if (o >= SH_LO && o <= SH_HI) esc = (((o - SH_LO) / CD) % 2) == 1;
      if (o >= 1 && o <= DONE_AT) begin
        if (o < SH_LO) k = 0;
        else if (o > SH_HI) k = DW - 1;
        else k = ((o - SH_LO) / CD) / 2;
        emo = tx[DW-1-k];
      end
      if (o == DONE_AT) begin
        ed[own] = 1'b1;
        last_rsp = rxw;
      end
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("done", 64'(done), 64'(ed));
    chk("busy", 64'(busy), 64'(eb));
    chk("cs_n", 64'(cs_n), 64'(ecs));
    chk("sclk", 64'(sclk), 64'(esc));
    chk("mosi", 64'(mosi), 64'(emo));
    chk("rsp_data", 64'(rsp_data), 64'(last_rsp));
    // slave: present next bit after each observed rising sclk
    if (sclk && !psclk) rises++;
    psclk = sclk;
    miso = (act && rises < DW) ? rxw[DW-1-rises] : 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (gseen[i]) pend[i] = 0;
      else if (pend[i] && act && $urandom_range(199) == 0) pend[i] = 0;
      if (!pend[i] && cyc > 5 && $urandom_range(99) == 0) begin
        pend[i] = 1;
        req_data[i*DW +: DW] = $urandom;
      end
      req[i] = pend[i];
    end
    gseen = '0;
    @(negedge clk);
    model_check();
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_cs_n"}, 64'(cs_n), 64'd1);
    chk({tag, "_sclk"}, 64'(sclk), 64'd0);
    chk({tag, "_mosi"}, 64'(mosi), 64'd0);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp"}, 64'(rsp_data), 64'd0);
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    reset_values("rst_mid");
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_done", 64'(done), 64'd0);
      chk("rst_hold_cs_n", 64'(cs_n), 64'd1);
    end
    rst_n = 1'b1;
    act = 0; rr = 0; last_rsp = '0;
    pend = '0; gseen = '0; psclk = 0; miso = 1'b0;
  endtask

  task automatic loopback();
    int tg, td, r1, r2, nr;
    bit ps;
    tg = -1; td = -1; r1 = -1; r2 = -1; nr = 0; ps = 0;
    @(posedge clk);
    #1;
    data2 = 8'($urandom);
    req2 = 2'b01;
    for (int c = 0; c < 100 && td < 0; c++) begin
      @(negedge clk);
      if (gnt2[0] && tg < 0) tg = c;
      if (sclk2 && !ps) begin
        nr++;
        r1 = r2;
        r2 = c;
      end
      ps = sclk2;
      if (done2[0]) begin
        td = c;
        chk("lb_rsp", 64'(rsp2), 64'(data2));
      end
      @(posedge clk);
      #1;
      if (tg >= 0) req2 = 2'b00;
    end
    chk("lb_latency", 64'(td - tg), 64'd36);
    chk("lb_rises", 64'(nr), 64'd8);
    chk("lb_period", 64'(r2 - r1), 64'd4);
  endtask

  bit did_rst = 0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_values("rst_init");
    pend[0] = 1;
    req_data[0 +: DW] = 32'hA5A5_0F0F;
    rst_n = 1'b1;
    while (cyc < 9000) begin
      step();
      if (!did_rst && cyc > 4000 && act && cyc - t0 == 100) begin
        did_rst = 1;
        mid_reset();
      end
    end
    chk("mid_reset_hit", 64'(did_rst), 64'd1);
    loopback();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
